// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among N_REQ requesters.
// A grant lasts until the owner drops its request or BURST_MAX beats have been
// written. The releasing owner then gets the lowest priority in the next search.
// Arbitration takes one IDLE cycle, so there is always a bubble between grants.
module fifo_push_arbiter #(
    parameter  int N_REQ     = 4,
    parameter  int DATA_W    = 8,
    parameter  int BURST_MAX = 4,
    localparam int OWN_W     = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ack,
    output logic                      push,
    output logic [DATA_W-1:0]         data_in,
    input  logic                      full,
    output logic                      busy,
    output logic [OWN_W-1:0]          owner
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [OWN_W-1:0]    r_owner;
    logic [OWN_W-1:0]    w_owner_nxt;
    logic [OWN_W-1:0]    r_rr_ptr;
    logic [OWN_W-1:0]    w_rr_ptr_nxt;
    logic [OWN_W-1:0]    w_owner_inc;
    logic [OWN_W-1:0]    w_pick;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic [CNT_W-1:0]    w_beat_cnt_nxt;
    logic [DATA_W-1:0]   r_data_hold;
    logic [DATA_W-1:0]   w_own_data;
    logic                w_own_req;
    logic                w_push;

    assign owner = r_owner;
    assign push  = w_push;

    // Owner + 1 with an explicit wrap, so non-power-of-2 N_REQ never yields an index >= N_REQ.
    assign w_owner_inc = (r_owner == OWN_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

    // Select the current owner's request bit and data slice.
    always_comb begin
        w_own_req  = 1'b0;
        w_own_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (r_owner == OWN_W'(i)) begin
                w_own_req  = req[i];
                w_own_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Round-robin search: first active request at rr_ptr, rr_ptr+1, ... modulo N_REQ.
    always_comb begin
        logic [OWN_W-1:0] w_idx;
        logic             w_found;
        w_pick  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_idx = OWN_W'((32'(r_rr_ptr) + k) % N_REQ);
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!w_found && (w_idx == OWN_W'(i)) && req[i]) begin
                    w_pick  = OWN_W'(i);
                    w_found = 1'b1;
                end
            end
        end
    end

    // Next-state logic and combinational write-port outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        w_push         = 1'b0;
        busy           = 1'b0;
        data_in        = r_data_hold;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_owner_nxt    = w_pick;
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = GRANT;
                end
            end
            GRANT: begin
                busy    = 1'b1;
                w_push  = w_own_req & ~full;
                data_in = w_own_data;
                if (!w_own_req) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = w_owner_inc;
                end else if (w_push && (r_beat_cnt == CNT_W'(BURST_MAX - 1))) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = w_owner_inc;
                end else if (w_push) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // One-hot acknowledge to the owner on each accepted beat.
    always_comb begin
        req_ack = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_ack[i] = w_push && (r_owner == OWN_W'(i));
        end
    end

    // State, grant bookkeeping and the data value held while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_beat_cnt  <= '0;
            r_data_hold <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            if (r_state == GRANT) begin
                r_data_hold <= w_own_data;
            end
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Scoreboard bench for fifo_push_arbiter: directed beats go to per-requester
// source queues and, in hand-computed grant order, to an expected-write queue.
module tb_fifo_push_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BM = 4;
    localparam int OW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            full;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ack;
    logic            push;
    logic [DW-1:0]   data_in;
    logic            busy;
    logic [OW-1:0]   owner;

    fifo_push_arbiter #(.N_REQ(N), .DATA_W(DW), .BURST_MAX(BM)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .req_ack  (req_ack),
        .push     (push),
        .data_in  (data_in),
        .full     (full),
        .busy     (busy),
        .owner    (owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           idx;
        logic [7:0]   data;
        bit           first;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  src_q[N][$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_push  = 0;
    int          grant_beats = 0;
    logic [N-1:0] ack_seen = '0;

    // Requester model: drop the acked beat after the edge, present the next one.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (ack_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            req[i] = (src_q[i].size() > 0);
            req_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
        end
    end

    // Monitor: every FIFO write must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t        e;
        logic [N-1:0] eack;
        if (!reset) begin
            ack_seen    = '0;
            grant_beats = 0;
        end else begin
            ack_seen = req_ack;
            if (!busy) grant_beats = 0;
            n_tests++;
            if (push) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_push: data_in=%h req_ack=%b owner=%0d, required no push",
                             data_in, req_ack, owner);
                end else begin
                    e    = exp_q.pop_front();
                    eack = N'(1) << e.idx;
                    if (data_in !== e.data || req_ack !== eack || owner !== OW'(e.idx) ||
                        ((grant_beats == 0) != e.first)) begin
                        n_fail++;
                        $display("FAIL push_beat: got data=%h ack=%b owner=%0d first=%0d, required data=%h ack=%b owner=%0d first=%0d",
                                 data_in, req_ack, owner, grant_beats == 0, e.data, eack, e.idx, e.first);
                    end
                end
                grant_beats++;
                n_push++;
            end else if (req_ack !== '0) begin
                n_fail++;
                $display("FAIL ack_without_push: req_ack=%b, required 0000", req_ack);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, expv);
        end
    endtask

    task automatic add_beat(input int idx, input logic [7:0] d, input bit first);
        exp_t e;
        e.idx   = idx;
        e.data  = d;
        e.first = first;
        src_q[idx].push_back(d);
        exp_q.push_back(e);
    endtask

    task automatic flush_all();
        exp_q.delete();
        for (int i = 0; i < N; i++) src_q[i].delete();
    endtask

    task automatic drain(input string name, input int max_cyc);
        int c;
        bit empty;
        c = 0;
        empty = 1'b0;
        while (c < max_cyc) begin
            empty = (exp_q.size() == 0);
            for (int i = 0; i < N; i++) if (src_q[i].size() > 0) empty = 1'b0;
            if (empty) break;
            @(posedge clk);
            c++;
        end
        chk({name, "_drain"}, 32'(empty), 32'd1);
        if (!empty) flush_all();
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic wait_pushes(input string name, input int target);
        int c;
        c = 0;
        while (n_push < target && c < 60) begin
            @(posedge clk);
            c++;
        end
        chk({name, "_reached"}, 32'(n_push >= target), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b0;
        full  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_push", 32'(push), 0);
        chk("rst_ack", 32'(req_ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_data", 32'(data_in), 0);
        reset = 1'b1;
        @(posedge clk);
        #2;
        chk("idle_busy", 32'(busy), 0);

        // All four request: grants 0,1,2,3,0 with 4 beats each.
        for (int r = 0; r < 5; r++) begin
            for (int b = 0; b < BM; b++) begin
                add_beat(r % N, 8'(((r % N) << 4) | ((r == 4 ? 4 : 0) + b)), b == 0);
            end
        end
        @(posedge clk);
        #2;
        chk("arb_latency_busy", 32'(busy), 0);
        chk("arb_latency_push", 32'(push), 0);
        @(posedge clk);
        #2;
        chk("first_grant_owner", 32'(owner), 0);
        chk("first_grant_push", 32'(push), 1);
        drain("all_req", 200);
        chk("all_req_last_owner", 32'(owner), 0);

        // Single requester 1, six beats: bubble after the fourth.
        for (int k = 0; k < 6; k++) add_beat(1, 8'hD0 + 8'(k), k == 0 || k == 4);
        drain("single", 100);

        // Backpressure after two beats of requester 1.
        base = n_push;
        for (int k = 0; k < 5; k++) add_beat(1, 8'h40 + 8'(k), k == 0 || k == 4);
        wait_pushes("bp", base + 2);
        #2;
        full = 1'b1;
        #1;
        chk("bp_push", 32'(push), 0);
        chk("bp_ack", 32'(req_ack), 0);
        chk("bp_busy", 32'(busy), 1);
        chk("bp_owner", 32'(owner), 1);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #3;
            chk("bp_hold_push", 32'(push), 0);
            chk("bp_hold_owner", 32'(owner), 1);
        end
        @(posedge clk);
        #2;
        full = 1'b0;
        drain("bp", 100);

        // Early drop by owner 3 with requester 0 waiting: wrap 3 -> 0.
        add_beat(3, 8'h35, 1'b1);
        add_beat(0, 8'h05, 1'b1);
        drain("early_drop", 100);
        chk("early_drop_owner", 32'(owner), 0);

        // Data routing: distinct slices, rr_ptr now 1.
        add_beat(1, 8'hA1, 1'b1);
        add_beat(2, 8'hA2, 1'b1);
        add_beat(3, 8'hA3, 1'b1);
        add_beat(0, 8'hA0, 1'b1);
        drain("routing", 100);

        // Reset mid-burst: owner 2 with one beat written.
        base = n_push;
        for (int k = 0; k < 4; k++) add_beat(2, 8'h20 + 8'(k), k == 0);
        wait_pushes("mid", base + 1);
        #2;
        chk("mid_push", 32'(push), 1);
        chk("mid_owner", 32'(owner), 2);
        reset = 1'b0;
        #1;
        chk("mid_rst_push", 32'(push), 0);
        chk("mid_rst_ack", 32'(req_ack), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_owner", 32'(owner), 0);
        flush_all();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        add_beat(0, 8'h50, 1'b1);
        add_beat(3, 8'h53, 1'b1);
        drain("post_rst", 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
